// File: rtl/deass_serializer.sv
// deass_serializer: framed single-wire transmitter (start, data LSB first, stop).
// Define DEASS_PARITY_EN to add an even-parity bit between the data and stop bits.
module deass_serializer #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             busy
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef DEASS_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic out_q, out_d;
  logic busy_q, busy_d;
`ifdef DEASS_PARITY_EN
  logic par_q, par_d;
`endif

  logic accept;
  logic cyc_last;

  assign din_ready = (state_q == S_IDLE) && !rst;
  assign out       = out_q;
  assign busy      = busy_q;

  // Next-state, counters and shifter; out/busy follow the next state.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef DEASS_PARITY_EN
    par_d    = par_q;
`endif
    accept   = din_valid && din_ready;
    cyc_last = (cyc_q == CYC_LAST);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          shift_d = din;
          cyc_d   = '0;
          bit_d   = '0;
`ifdef DEASS_PARITY_EN
          par_d   = ^din;
`endif
        end
      end
      S_START: begin
        if (cyc_last) begin
          cyc_d   = '0;
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cyc_last) begin
          cyc_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef DEASS_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
`ifdef DEASS_PARITY_EN
      S_PAR: begin
        if (cyc_last) begin
          cyc_d   = '0;
          state_d = S_STOP;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (cyc_last) begin
          cyc_d   = '0;
          state_d = S_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        bit_d   = '0;
      end
    endcase

    case (state_d)
      S_START: out_d = 1'b0;
      S_DATA:  out_d = shift_d[0];
`ifdef DEASS_PARITY_EN
      S_PAR:   out_d = par_d;
`endif
      default: out_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef DEASS_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
`ifdef DEASS_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_deass_serializer.sv
// tb_deass_serializer: directed frames on three instances (4, 1, 2 cycles/bit).
// Expected line bits are hand-written per word; parity bit used when enabled.
module tb_deass_serializer;

`ifdef DEASS_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  localparam int NB = PE ? 11 : 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v;
  logic [2:0] dv_v;
  logic [2:0] rdy_v;
  logic [2:0] out_v;
  logic [2:0] busy_v;
  logic [7:0] din_v [3];

  int n_cmp = 0;
  int n_bad = 0;

  deass_serializer #(.WIDTH(8), .BIT_CYCLES(4)) u_a (
    .clk(clk), .rst(rst_v[0]), .din(din_v[0]), .din_valid(dv_v[0]),
    .din_ready(rdy_v[0]), .out(out_v[0]), .busy(busy_v[0])
  );
  deass_serializer #(.WIDTH(8), .BIT_CYCLES(1)) u_b (
    .clk(clk), .rst(rst_v[1]), .din(din_v[1]), .din_valid(dv_v[1]),
    .din_ready(rdy_v[1]), .out(out_v[1]), .busy(busy_v[1])
  );
  deass_serializer #(.WIDTH(8), .BIT_CYCLES(2)) u_c (
    .clk(clk), .rst(rst_v[2]), .din(din_v[2]), .din_valid(dv_v[2]),
    .din_ready(rdy_v[2]), .out(out_v[2]), .busy(busy_v[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line bits in transmit order, index 0 = start bit.
  function automatic logic [15:0] mk(input logic [7:0] w, input logic p);
    logic [15:0] s;
    if (PE) s = {5'b0, 1'b1, p, w, 1'b0};
    else    s = {6'b0, 1'b1, w, 1'b0};
    return s;
  endfunction

  // Caller leaves din/valid set in IDLE; acceptance happens on the next edge.
  task automatic frame(input int k, input int bc, input logic [15:0] seq,
                       input bit hold, input logic [7:0] nxt,
                       input string tag);
    logic [31:0] got;
    logic [31:0] exp;
    logic bz;
    tick();
    din_v[k] = nxt;
    if (!hold) dv_v[k] = 1'b0;
    bz = 1'b1;
    for (int j = 0; j < NB; j++) begin
      got = '0;
      for (int c = 0; c < bc; c++) begin
        if (j != 0 || c != 0) tick();
        got[c] = out_v[k];
        bz = bz & busy_v[k] & ~rdy_v[k];
      end
      exp = seq[j] ? ((32'd1 << bc) - 32'd1) : 32'd0;
      chk($sformatf("%s_bit%0d", tag, j), got, exp);
    end
    chk({tag, "_busy"}, {31'b0, bz}, 32'd1);
    tick();
    chk({tag, "_end"}, {29'b0, rdy_v[k], busy_v[k], out_v[k]}, 32'h5);
  endtask

  initial begin
    rst_v = 3'b111;
    dv_v  = 3'b111;
    for (int i = 0; i < 3; i++) din_v[i] = 8'h5A;

    // Reset and valid together: nothing starts.
    tick();
    tick();
    chk("rst_out", {31'b0, out_v[0]}, 32'd1);
    chk("rst_busy", {31'b0, busy_v[0]}, 32'd0);
    chk("rst_rdy", {29'b0, rdy_v}, 32'd0);
    rst_v = 3'b000;
    dv_v  = 3'b000;
    #1;
    chk("rdy_after_rst", {29'b0, rdy_v}, 32'h7);
    tick();
    chk("idle_line", {26'b0, out_v, busy_v}, 32'h38);

    // Basic frame; din changes after acceptance must not matter.
    din_v[0] = 8'hA5;
    dv_v[0]  = 1'b1;
    frame(0, 4, mk(8'hA5, 1'b0), 1'b0, 8'h00, "a5");

    // Stalled producer: valid held, second word queued behind the first.
    din_v[0] = 8'h3C;
    dv_v[0]  = 1'b1;
    frame(0, 4, mk(8'h3C, 1'b0), 1'b1, 8'hC3, "3c");
    frame(0, 4, mk(8'hC3, 1'b0), 1'b0, 8'h00, "c3");

    // Reset during data bit 3 of 0xFF.
    din_v[0] = 8'hFF;
    dv_v[0]  = 1'b1;
    tick();
    dv_v[0] = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    chk("ff_mid_busy", {31'b0, busy_v[0]}, 32'd1);
    rst_v[0] = 1'b1;
    tick();
    chk("ff_rst", {29'b0, rdy_v[0], busy_v[0], out_v[0]}, 32'h1);
    rst_v[0] = 1'b0;
    #1;
    chk("ff_rdy", {31'b0, rdy_v[0]}, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("ff_quiet", {30'b0, busy_v[0], out_v[0]}, 32'h1);
    din_v[0] = 8'h01;
    dv_v[0]  = 1'b1;
    frame(0, 4, mk(8'h01, 1'b1), 1'b0, 8'h00, "01");

    // One cycle per bit.
    din_v[1] = 8'h80;
    dv_v[1]  = 1'b1;
    frame(1, 1, mk(8'h80, 1'b1), 1'b0, 8'h00, "80");

    // Two cycles per bit; parity 1 then 0 when enabled.
    din_v[2] = 8'h07;
    dv_v[2]  = 1'b1;
    frame(2, 2, mk(8'h07, 1'b1), 1'b0, 8'h00, "07");
    din_v[2] = 8'h03;
    dv_v[2]  = 1'b1;
    frame(2, 2, mk(8'h03, 1'b0), 1'b0, 8'h00, "03");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
